// File: rtl/b2_mux_4_1_rr.sv
// 4:1 round-robin valid/ready merge into a one-entry output register; 1-cycle latency, inputs stall while the
// held beat is not taken. Optional per-channel accepted-beat counters are built only under B2_MUX_STATS_EN.
module b2_mux_4_1_rr #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  input  logic [3:0]    din_valid,
  output logic [3:0]    din_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [1:0]    dout_sel,
  output logic [7:0]    cnt0,
  output logic [7:0]    cnt1,
  output logic [7:0]    cnt2,
  output logic [7:0]    cnt3
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr;
  logic          load;
  logic          gnt_any;
  logic [1:0]    gnt_idx;
  logic [DW-1:0] gnt_dat;

  // Lowest offset from ptr wins: iterate downwards so the last hit is the nearest channel.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (din_valid[ptr + 2'(k)]) begin
        gnt_any = 1'b1;
        gnt_idx = ptr + 2'(k);
      end
    end
  end

  always_comb begin
    case (gnt_idx)
      2'd0:    gnt_dat = din0;
      2'd1:    gnt_dat = din1;
      2'd2:    gnt_dat = din2;
      default: gnt_dat = din3;
    endcase
  end

  always_comb begin
    state_nxt = state;
    load      = rst_n && ((state == EMPTY) || dout_ready);
    din_ready = 4'b0000;
    if (load) begin
      if (gnt_any) begin
        din_ready = 4'b0001 << gnt_idx;
        state_nxt = FULL;
      end else begin
        state_nxt = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      dout     <= '0;
      dout_sel <= 2'd0;
      ptr      <= 2'd0;
    end else begin
      state <= state_nxt;
      if (load && gnt_any) begin
        dout     <= gnt_dat;
        dout_sel <= gnt_idx;
        ptr      <= gnt_idx + 2'd1;
      end
    end
  end

  assign dout_valid = (state == FULL);

`ifdef B2_MUX_STATS_EN
  logic [7:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (din_ready[i] && din_valid[i] && (cnt_q[i] != 8'hFF)) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`else
  assign cnt0 = 8'd0;
  assign cnt1 = 8'd0;
  assign cnt2 = 8'd0;
  assign cnt3 = 8'd0;
`endif

endmodule

// File: tb/tb_b2_mux_4_1_rr.sv
// Bench for b2_mux_4_1_rr: directed literal scenarios plus randomized traffic against a behavioural model.
module tb_b2_mux_4_1_rr;

`ifdef B2_MUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din [4];
  logic [3:0] din_valid;
  logic [3:0] din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [1:0] dout_sel;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // behavioural model of the output register and arbitration pointer
  bit         m_full = 1'b0;
  logic [7:0] m_dout = 8'd0;
  int         m_sel  = 0;
  int         m_ptr  = 0;
  int         m_cnt [4] = '{0, 0, 0, 0};

  b2_mux_4_1_rr #(.DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din0      (din[0]),
    .din1      (din[1]),
    .din2      (din[2]),
    .din3      (din[3]),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_sel  (dout_sel),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    r = 4'b0000;
    if (!rst_n) return r;
    if (m_full && !dout_ready) return r;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (din_valid[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [3:0] r;
    if (!rst_n) begin
      m_full = 1'b0;
      m_dout = 8'd0;
      m_sel  = 0;
      m_ptr  = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      r = exp_ready();
      if (r != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (r[i]) begin
            m_full = 1'b1;
            m_dout = din[i];
            m_sel  = i;
            m_ptr  = (i + 1) % 4;
            if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end else if (!m_full || dout_ready) begin
        m_full = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model din_ready", 32'(din_ready), 32'(exp_ready()));
      check("model dout_valid", 32'(dout_valid), 32'(m_full));
      check("model dout", 32'(dout), 32'(m_dout));
      check("model dout_sel", 32'(dout_sel), 32'(m_sel));
      check("model cnt0", 32'(cnt0), STATS ? 32'(m_cnt[0]) : 32'd0);
      check("model cnt1", 32'(cnt1), STATS ? 32'(m_cnt[1]) : 32'd0);
      check("model cnt2", 32'(cnt2), STATS ? 32'(m_cnt[2]) : 32'd0);
      check("model cnt3", 32'(cnt3), STATS ? 32'(m_cnt[3]) : 32'd0);
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rot_exp [5];
    rot_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

    // reset with every channel requesting
    rst_n = 1'b0;
    din_valid = 4'b1111;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 8'hA0 + 8'(i);
    drive_edge();
    cmp_en = 1'b1;
    drive_edge();
    @(negedge clk);
    check("reset din_ready", 32'(din_ready), 32'h0);
    check("reset dout_valid", 32'(dout_valid), 32'h0);
    check("reset dout", 32'(dout), 32'h0);
    check("reset cnt", {cnt0, cnt1, cnt2, cnt3}, 32'h0);

    // rotation 0,1,2,3,0 with one-cycle latency
    drive_edge();
    rst_n = 1'b1;
    @(negedge clk);
    check("rot first din_ready", 32'(din_ready), 32'b0001);
    check("rot first dout_valid", 32'(dout_valid), 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rot dout", 32'(dout), 32'(rot_exp[k]));
      check("rot dout_sel", 32'(dout_sel), 32'(k % 4));
    end

    // backpressure holding 8'h55
    drive_edge();
    din[0] = 8'h55;
    din_valid = 4'b0001;
    drive_edge();
    dout_ready = 1'b0;
    din_valid = 4'b1111;
    din[0] = 8'hA0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp dout hold", 32'(dout), 32'h55);
      check("bp din_ready", 32'(din_ready), 32'h0);
      if (k < 4) @(posedge clk);
    end
    drive_edge();
    dout_ready = 1'b1;
    @(negedge clk);
    check("bp release din_ready", 32'(din_ready), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    check("bp release dout", 32'(dout), 32'hA1);

    // reset while holding 8'h33, then sparse requests
    drive_edge();
    din[2] = 8'h33;
    din_valid = 4'b0100;
    drive_edge();
    rst_n = 1'b0;
    din_valid = 4'b0000;
    @(negedge clk);
    check("pre-reset dout", 32'(dout), 32'h33);
    drive_edge();
    rst_n = 1'b1;
    din[2] = 8'hC2;
    din_valid = 4'b0100;
    @(negedge clk);
    check("midreset dout_valid", 32'(dout_valid), 32'h0);
    check("midreset dout", 32'(dout), 32'h0);
    check("sparse grant2", 32'(din_ready), 32'b0100);
    drive_edge();
    din[1] = 8'hB1;
    din_valid = 4'b0010;
    @(negedge clk);
    check("sparse dout", 32'(dout), 32'hC2);
    check("sparse grant1", 32'(din_ready), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    check("sparse dout2", 32'(dout), 32'hB1);
    check("sparse sel2", 32'(dout_sel), 32'd1);

    // randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      drive_edge();
      rst_n = ($urandom_range(0, 149) != 0);
      din_valid = 4'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
    end

    // 300 transfers on channel 1 saturate its counter
    drive_edge();
    rst_n = 1'b0;
    drive_edge();
    rst_n = 1'b1;
    din_valid = 4'b0010;
    dout_ready = 1'b1;
    repeat (300) drive_edge();
    din_valid = 4'b0000;
    @(negedge clk);
    check("stats cnt1", 32'(cnt1), STATS ? 32'd255 : 32'd0);
    check("stats others", {8'h0, cnt0, cnt2, cnt3}, 32'h0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b2_mux_4_1_rr.md
B2_MUX_4_1_RR -- requirements
Module: b2_mux_4_1_rr

Interface
- REQ-001 Parameter DW, default 8: data width of every input and output data port.
- REQ-002 clk  input  1  single clock; all state updates on the rising edge.
- REQ-003 rst_n  input  1  reset, synchronous, active-low.
- REQ-004 din0..din3  input  DW each  channel 0..3 data.
- REQ-005 din_valid  input  4  bit i: channel i offers a beat.
- REQ-006 din_ready  output  4  bit i: channel i beat accepted this cycle; one-hot or zero; combinational.
- REQ-007 dout  output  DW  registered merged data.
- REQ-008 dout_valid  output  1  registered; dout holds a beat.
- REQ-009 dout_ready  input  1  downstream accepts the beat.
- REQ-010 dout_sel  output  2  registered source channel of the current dout beat.
- REQ-011 cnt0..cnt3  output  8 each  per-channel accepted-beat counters (see Configuration).

Function
- REQ-012 The block SHALL merge four valid/ready streams into one stream through a single-entry output register; it is the inverse of the team's 1-to-4 demux.
- REQ-013 A transfer on either side SHALL occur only when valid and ready are both high on the same rising edge.
- REQ-014 Output register states: EMPTY (dout_valid=0) and FULL (dout_valid=1).
- REQ-015 load = (EMPTY) or (FULL and dout_ready); din_ready SHALL be all-zero when load=0.
- REQ-016 When load=1, grant SHALL go to the first channel with din_valid set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); din_ready SHALL equal the one-hot grant.
- REQ-017 On a grant to channel i: dout<=din_i, dout_sel<=i, dout_valid<=1, ptr<=(i+1) mod 4.
- REQ-018 FULL with dout_ready=1 and no din_valid: go to EMPTY; dout and dout_sel SHALL hold their last values.
- REQ-019 Latency is 1 cycle from input acceptance to dout_valid; sustained throughput is 1 beat per cycle when dout_ready stays high.
- REQ-020 FULL with dout_ready=0: dout, dout_sel and dout_valid SHALL hold; no input is accepted; ptr holds.
- REQ-021 ptr SHALL change only on a grant; an idle cycle SHALL not advance it.
- REQ-022 Every grant SHALL come from a channel whose din_valid is high; no beat is dropped or duplicated.
- REQ-023 Fairness: with all four channels continuously valid, grants SHALL rotate 0,1,2,3,0...

Reset
- REQ-024 While rst_n=0 at a rising edge: dout=0, dout_sel=0, dout_valid=0, ptr=0, cnt0..cnt3=0.
- REQ-025 While rst_n=0, din_ready SHALL be 4'b0000.
- REQ-026 Reset asserted mid-transfer SHALL discard the held beat; the first cycle after release SHALL be EMPTY with grant priority starting at channel 0.

Configuration
- REQ-027 Macro B2_MUX_STATS_EN controls the counters.
- REQ-028 Macro defined: cnt_i SHALL increment by 1 on each channel-i input transfer and saturate at 255 without wrapping.
- REQ-029 Macro undefined: cnt0..cnt3 ports SHALL remain present, tied to 0, and no counter flops are built.

Verification
- REQ-030 Reset: rst_n=0 for 2 cycles with all din_valid=1 -> din_ready=0000, dout_valid=0, dout=0, cnt*=0.
- REQ-031 Rotation: din_valid=1111, din_i=8'hA0+i, dout_ready=1 -> dout_sel sequence 0,1,2,3,0 and dout sequence A0,A1,A2,A3,A0 with 1-cycle latency.
- REQ-032 Backpressure: FULL with dout=8'h55, dout_ready=0 for 5 cycles -> dout holds 55, din_ready=0000; on dout_ready=1 the next grant loads in the same cycle.
- REQ-033 Sparse: only din_valid[2]=1, ptr=0 -> grant to 2, ptr becomes 3; next lone request on 1 -> granted immediately.
- REQ-034 Reset mid-stream: FULL with dout=8'h33, rst_n=0 for 1 cycle -> dout_valid=0, dout=0, next grant searches from channel 0.
- REQ-035 Stats (B2_MUX_STATS_EN): 300 transfers on channel 1 -> cnt1=255 and others 0; without the macro, all cnt*=0.
